// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort_engine block.
// Optional argsort tags are built when SORT_INDEX_EN is defined.
package sort_pkg;

   typedef enum logic [1:0] {
      S_LOAD,
      S_SORT,
      S_DRAIN
   } state_e;

   // Ceiling log2, minimum result 0; used to size counters and tags.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Stream interface of sort_engine: input frame stream and sorted output stream.
// out_idx (and its IDX_W parameter) exist only when SORT_INDEX_EN is defined.
interface sort_engine_if #(
   parameter int DATA_W = 32
`ifdef SORT_INDEX_EN
   , parameter int IDX_W = 7
`endif
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_desc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
`ifdef SORT_INDEX_EN
   logic [IDX_W-1:0]  out_idx;
`endif

   modport master (
`ifdef SORT_INDEX_EN
      input  out_idx,
`endif
      output in_valid, in_data, in_desc, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
`ifdef SORT_INDEX_EN
      output out_idx,
`endif
      input  in_valid, in_data, in_desc, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/sort_cmp_swap.sv
// One compare-exchange cell: lo_o/hi_o are the lower/higher array positions.
// Equal operands never swap, which keeps the overall sort stable.
module sort_cmp_swap #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              desc_i,
   output logic [DATA_W-1:0] lo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic              swapped_o
);
   // swap strictly out-of-order pairs for the requested direction
   always_comb begin
      swapped_o = (a_i != b_i) && ((a_i > b_i) ^ desc_i);
      lo_o      = swapped_o ? b_i : a_i;
      hi_o      = swapped_o ? a_i : b_i;
   end
endmodule

// File: rtl/sort_engine.sv
// Frame sorter: LOAD DEPTH words, odd-even transposition SORT, DRAIN in order.
// Define SORT_INDEX_EN to carry arrival-index tags and expose bus.out_idx.
module sort_engine
   import sort_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 100
) (
   input  logic         clk,
   input  logic         rst_n,
   sort_engine_if.slave bus,
   output logic         busy
);
   localparam int IDX_W = clog2(DEPTH);
   localparam int NCELL = DEPTH / 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              desc_q, desc_d;
   logic              swap_q, swap_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
`ifdef SORT_INDEX_EN
   logic [IDX_W-1:0]  tag_q [DEPTH];
   logic [IDX_W-1:0]  tag_d [DEPTH];
`endif

   // During SORT, cnt_q doubles as the phase counter; bit 0 selects odd phase.
   logic              odd;
   logic [DATA_W-1:0] ca  [NCELL];
   logic [DATA_W-1:0] cb  [NCELL];
   logic [DATA_W-1:0] clo [NCELL];
   logic [DATA_W-1:0] chi [NCELL];
   logic [NCELL-1:0]  csw, cen;
   logic              any_swap;

   assign odd      = cnt_q[0];
   assign any_swap = |(csw & cen);

   // Cell k handles (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases;
   // the last cell idles on odd phases when DEPTH is even.
   for (genvar k = 0; k < NCELL; k++) begin : g_cell
      if (2 * k + 2 < DEPTH) begin : g_full
         assign ca[k]  = odd ? mem_q[2*k+1] : mem_q[2*k];
         assign cb[k]  = odd ? mem_q[2*k+2] : mem_q[2*k+1];
         assign cen[k] = 1'b1;
      end else begin : g_edge
         assign ca[k]  = mem_q[2*k];
         assign cb[k]  = mem_q[2*k+1];
         assign cen[k] = ~odd;
      end
      sort_cmp_swap #(.DATA_W(DATA_W)) u_cell (
         .a_i      (ca[k]),
         .b_i      (cb[k]),
         .desc_i   (desc_q),
         .lo_o     (clo[k]),
         .hi_o     (chi[k]),
         .swapped_o(csw[k])
      );
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         desc_q  <= 1'b0;
         swap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         desc_q  <= desc_d;
         swap_q  <= swap_d;
      end
   end

   // Frame storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
`ifdef SORT_INDEX_EN
      tag_q <= tag_d;
`endif
   end

   // Next-state, array update and handshake outputs.
   always_comb begin
      logic [IDX_W-1:0] li;
      state_d       = state_q;
      cnt_d         = cnt_q;
      desc_d        = desc_q;
      swap_d        = swap_q;
      mem_d         = mem_q;
`ifdef SORT_INDEX_EN
      tag_d         = tag_q;
      bus.out_idx   = tag_q[cnt_q];
`endif
      li            = '0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = mem_q[cnt_q];
      busy          = 1'b0;

      case (state_q)
         S_LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               mem_d[cnt_q] = bus.in_data;
`ifdef SORT_INDEX_EN
               tag_d[cnt_q] = cnt_q;
`endif
               if (cnt_q == '0) desc_d = bus.in_desc;
               if (cnt_q == LAST) begin
                  state_d = S_SORT;
                  cnt_d   = '0;
                  swap_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_SORT: begin
            busy = 1'b1;
            for (int unsigned k = 0; k < NCELL; k++) begin
               li = IDX_W'(2 * k + (odd ? 1 : 0));
               if (cen[k]) begin
                  mem_d[li]      = clo[k];
                  mem_d[li+1'b1] = chi[k];
`ifdef SORT_INDEX_EN
                  if (csw[k]) begin
                     tag_d[li]      = tag_q[li+1'b1];
                     tag_d[li+1'b1] = tag_q[li];
                  end
`endif
               end
            end
            // a quiet even/odd pair means sorted; DEPTH phases always suffice
            if ((odd && !(swap_q || any_swap)) || (cnt_q == LAST)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            swap_d = odd ? 1'b0 : any_swap;
         end
         S_DRAIN: begin
            bus.out_valid = 1'b1;
            bus.out_last  = (cnt_q == LAST);
            if (bus.out_ready) begin
               if (cnt_q == LAST) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_LOAD;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: three instances (DEPTH 4, 5, 100)
// share one stimulus path selected by sel; expected output is a stable rank sort.
module tb_sort_engine;
   import sort_pkg::*;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_desc = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   int            sel = 0;

   always #5 clk = ~clk;

`ifdef SORT_INDEX_EN
   sort_engine_if #(.DATA_W(DW), .IDX_W(clog2(4)))   b4 ();
   sort_engine_if #(.DATA_W(DW), .IDX_W(clog2(5)))   b5 ();
   sort_engine_if #(.DATA_W(DW), .IDX_W(clog2(100))) b100 ();
`else
   sort_engine_if #(.DATA_W(DW)) b4 ();
   sort_engine_if #(.DATA_W(DW)) b5 ();
   sort_engine_if #(.DATA_W(DW)) b100 ();
`endif

   logic busy4, busy5, busy100;

   sort_engine #(.DATA_W(DW), .DEPTH(4))   u_d4   (.clk(clk), .rst_n(rst_n), .bus(b4),   .busy(busy4));
   sort_engine #(.DATA_W(DW), .DEPTH(5))   u_d5   (.clk(clk), .rst_n(rst_n), .bus(b5),   .busy(busy5));
   sort_engine #(.DATA_W(DW), .DEPTH(100)) u_d100 (.clk(clk), .rst_n(rst_n), .bus(b100), .busy(busy100));

   assign b4.in_valid    = in_valid && (sel == 0);
   assign b4.in_data     = in_data;
   assign b4.in_desc     = in_desc;
   assign b4.out_ready   = out_ready && (sel == 0);
   assign b5.in_valid    = in_valid && (sel == 1);
   assign b5.in_data     = in_data;
   assign b5.in_desc     = in_desc;
   assign b5.out_ready   = out_ready && (sel == 1);
   assign b100.in_valid  = in_valid && (sel == 2);
   assign b100.in_data   = in_data;
   assign b100.in_desc   = in_desc;
   assign b100.out_ready = out_ready && (sel == 2);

   logic          m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [DW-1:0] m_out_data;
   logic [7:0]    m_out_idx;

   always_comb begin
      m_in_ready  = b4.in_ready;
      m_out_valid = b4.out_valid;
      m_out_data  = b4.out_data;
      m_out_last  = b4.out_last;
      m_busy      = busy4;
      m_out_idx   = '0;
`ifdef SORT_INDEX_EN
      m_out_idx   = 8'(b4.out_idx);
`endif
      if (sel == 1) begin
         m_in_ready  = b5.in_ready;
         m_out_valid = b5.out_valid;
         m_out_data  = b5.out_data;
         m_out_last  = b5.out_last;
         m_busy      = busy5;
`ifdef SORT_INDEX_EN
         m_out_idx   = 8'(b5.out_idx);
`endif
      end else if (sel == 2) begin
         m_in_ready  = b100.in_ready;
         m_out_valid = b100.out_valid;
         m_out_data  = b100.out_data;
         m_out_last  = b100.out_last;
         m_busy      = busy100;
`ifdef SORT_INDEX_EN
         m_out_idx   = 8'(b100.out_idx);
`endif
      end
   end

   int            nvec = 0;
   int            nerr = 0;
   logic [DW-1:0] vals  [100];
   logic [DW-1:0] exp_v [100];
   logic [7:0]    exp_i [100];

   // Stable sort by rank: an element's output slot is the number of elements
   // that must precede it (strictly better key, or equal key arriving earlier).
   function automatic void build_expected(input int n, input bit desc);
      for (int i = 0; i < n; i++) begin
         int rank = 0;
         for (int j = 0; j < n; j++) begin
            if ((desc ? (vals[j] > vals[i]) : (vals[j] < vals[i])) ||
                (vals[j] == vals[i] && j < i))
               rank++;
         end
         exp_v[rank] = vals[i];
         exp_i[rank] = 8'(i);
      end
   endfunction

   task automatic send_and_sort(input int n, input bit desc, input bit inject,
                                input int bmin, input int bmax);
      int w;
      int nb;
      build_expected(n, desc);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         in_desc  = (i == 0) ? desc : ~desc;
         w = 0;
         while (!m_in_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (w >= 50) begin
            nvec++; nerr++;
            $display("FAIL load_wait: in_ready=%0b required 1", m_in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      nb = 0;
      while (m_busy && nb < n + 10) begin
         nvec++;
         if (m_in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL in_ready_sort: got %0b required 0", m_in_ready);
         end
         if (inject) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
         end
         nb++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      nvec++;
      if (nb < bmin || nb > bmax) begin
         nerr++;
         $display("FAIL busy_cycles: got %0d required %0d..%0d", nb, bmin, bmax);
      end
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random
   task automatic drain(input int n, input int mode, input int limit);
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      while (k < limit && cyc < n * 8 + 20) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         nvec++;
         if (m_out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL out_valid: got %0b required 1 (elem %0d)", m_out_valid, k);
         end else begin
            nvec++;
            if (m_out_data !== exp_v[k]) begin
               nerr++;
               $display("FAIL out_data[%0d]: got %0d required %0d", k, m_out_data, exp_v[k]);
            end
            nvec++;
            if (m_out_last !== (k == n - 1)) begin
               nerr++;
               $display("FAIL out_last[%0d]: got %0b required %0b", k, m_out_last, (k == n - 1));
            end
`ifdef SORT_INDEX_EN
            nvec++;
            if (m_out_idx !== exp_i[k]) begin
               nerr++;
               $display("FAIL out_idx[%0d]: got %0d required %0d", k, m_out_idx, exp_i[k]);
            end
`endif
         end
         if (m_out_valid && out_ready) k++;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      nvec++;
      if (k < limit) begin
         nerr++;
         $display("FAIL drain_count: got %0d required %0d", k, limit);
      end
      if (limit == n) begin
         nvec++;
         if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL frame_end: out_valid=%0b in_ready=%0b required 0/1", m_out_valid, m_in_ready);
         end
      end
   endtask

   task automatic check_idle(input string tag);
      nvec++;
      if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_out_last !== 1'b0 || m_busy !== 1'b0) begin
         nerr++;
         $display("FAIL %s: in_ready=%0b out_valid=%0b out_last=%0b busy=%0b required 1/0/0/0",
                  tag, m_in_ready, m_out_valid, m_out_last, m_busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_idle("reset_state");
      end
      sel = 0;
      @(negedge clk);
   endtask

   task automatic test_asc4();
      sel = 0;
      vals[0] = 7; vals[1] = 3; vals[2] = 9; vals[3] = 1;
      send_and_sort(4, 1'b0, 1'b0, 2, 4);
      drain(4, 0, 4);
   endtask

   task automatic test_desc4_stable();
      sel = 0;
      vals[0] = 2; vals[1] = 8; vals[2] = 5; vals[3] = 5;
      send_and_sort(4, 1'b1, 1'b0, 2, 4);
      drain(4, 0, 4);
   endtask

   task automatic test_sorted5();
      sel = 1;
      for (int i = 0; i < 5; i++) vals[i] = 16'(i + 1);
      send_and_sort(5, 1'b0, 1'b0, 2, 2);
      drain(5, 0, 5);
   endtask

   task automatic test_reverse100();
      sel = 2;
      for (int i = 0; i < 100; i++) vals[i] = 16'(99 - i);
      send_and_sort(100, 1'b0, 1'b0, 100, 100);
      drain(100, 0, 100);
   endtask

   task automatic test_stall_and_ignore();
      sel = 0;
      for (int i = 0; i < 4; i++) vals[i] = 16'($urandom_range(0, 300));
      send_and_sort(4, 1'b0, 1'b1, 2, 4);
      drain(4, 1, 4);
   endtask

   task automatic test_reset_mid_drain();
      sel = 0;
      vals[0] = 5; vals[1] = 9; vals[2] = 2; vals[3] = 7;
      send_and_sort(4, 1'b0, 1'b0, 2, 4);
      drain(4, 0, 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("reset_mid_drain");
      vals[0] = 4; vals[1] = 1; vals[2] = 3; vals[3] = 2;
      send_and_sort(4, 1'b0, 1'b0, 2, 4);
      drain(4, 0, 4);
   endtask

   task automatic test_random();
      for (int f = 0; f < 12; f++) begin
         int  n;
         bit  dsc;
         bit  narrow;
         sel    = int'($urandom_range(0, 2));
         n      = (sel == 0) ? 4 : (sel == 1) ? 5 : 100;
         dsc    = 1'($urandom_range(0, 1));
         narrow = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++)
            vals[i] = narrow ? 16'($urandom_range(0, 7)) : 16'($urandom);
         send_and_sort(n, dsc, 1'b1, 2, n);
         drain(n, 2, n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_asc4();
      test_desc4_stable();
      test_sorted5();
      test_reverse100();
      test_stall_and_ignore();
      test_reset_mid_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/sort_engine.md
Name: sort_engine

Overview:
- Sequential, parametrised successor to the combinational array sorter.
- Accepts a frame of DEPTH words over a valid/ready stream, sorts them in place with odd-even transposition (DEPTH/2 parallel compare-exchange cells per cycle), then streams them out in sorted order.
- Ascending or descending order, selected per frame; terminates early once the array is sorted.
- Sits between a producer FIFO and a downstream consumer in the data-path utility library.

Parameters:
- DATA_W, 32, element width in bits (unsigned compare).
- DEPTH, 100, elements per frame; must be >= 2; odd values allowed.
- IDX_W, $clog2(DEPTH), width of the element counter and index (derived; not overridden).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input element valid.
- in_ready  output  1  engine can accept an element.
- in_data  input  DATA_W  input element.
- in_desc  input  1  order for frame (1 = descending); sampled with the first accepted element.
- out_valid  output  1  output element valid.
- out_ready  input  1  consumer accepts the element.
- out_data  output  DATA_W  sorted element.
- out_last  output  1  high with the final (DEPTH-th) output element.
- busy  output  1  high in SORT state.
- out_idx  output  IDX_W  original arrival index of out_data (SORT_INDEX_EN only).

Behaviour:
- Handshake: a transfer occurs when valid && ready on a rising edge. out_data, out_last and out_idx hold stable while out_valid && !out_ready.
- Reset (rst_n low at an edge): state=LOAD, cnt=0, in_ready=1, out_valid=0, out_last=0, busy=0. Array contents are don't-care. Reset mid-frame discards the frame immediately; no partial output.
- LOAD:
  - in_ready=1. Each transfer writes mem[cnt] and increments cnt.
  - The first transfer latches desc <= in_desc.
  - The transfer with cnt==DEPTH-1 moves to SORT next cycle, with cnt=0, phase=0 and the swap flag cleared.
- SORT:
  - in_ready=0, busy=1. One phase per cycle.
  - Even phase compares pairs (0,1),(2,3)…; odd phase compares (1,2),(3,4)…
  - Swap when (mem[k] > mem[k+1]) XOR desc, with equal values never swapped, so the sort is stable.
  - Record whether any swap occurred in an even/odd phase pair.
  - Exit to DRAIN after an odd phase when neither phase of the pair swapped, or after DEPTH phases total, whichever comes first.
  - Latency: minimum 2 cycles (already-sorted input), maximum DEPTH cycles.
- DRAIN:
  - out_valid=1, out_data=mem[cnt].
  - Each transfer increments cnt; out_last=(cnt==DEPTH-1).
  - The final transfer returns to LOAD next cycle with cnt=0 and in_ready=1. There is no overlap between frames.
- out_valid may wait arbitrarily on out_ready; there is no timeout.
- in_valid in SORT/DRAIN is ignored, because in_ready=0.
- Counter wrap is never reached; cnt saturates at the frame boundary by construction.

Optional Feature:
- SORT_INDEX_EN defined:
  - Each element carries an IDX_W tag equal to its arrival position (0..DEPTH-1).
  - The tag moves with its element through every swap and is presented on out_idx, so the block acts as an argsort.
- Undefined: the out_idx port and tag storage are absent; all other behaviour is identical.

Decomposition:
- Package sort_pkg: state enum (S_LOAD, S_SORT, S_DRAIN) and a function computing the ceiling-log2 of DEPTH.
- Sub-module sort_cmp_swap: one combinational compare-exchange cell with a desc input, a/b in, lo/hi out and a swapped flag. It is instantiated DEPTH/2 times by a generate loop, with the phase muxing pairs.

Test Plan:
- DEPTH=4, ascending, input 7,3,9,1 -> output 1,3,7,9; out_last on 9; busy high 4 cycles or fewer.
- DEPTH=4, in_desc=1, input 2,8,5,5 -> output 8,5,5,2; with SORT_INDEX_EN, out_idx=1,2,3,0 (stability).
- DEPTH=5, ascending, already sorted 1,2,3,4,5 -> busy exactly 2 cycles; output unchanged.
- DEPTH=100, reverse-ordered 99..0 -> output 0..99; busy exactly 100 cycles.
- out_ready toggled 1,0,0,1 during drain -> out_data held while stalled; no element lost or duplicated. in_valid asserted during SORT -> ignored.
- rst_n low for one cycle mid-DRAIN after 2 outputs -> next cycle out_valid=0, in_ready=1; a fresh frame of 4,1,3,2 sorts to 1,2,3,4.
